// File: rtl/m_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// m_vga_write_arbiter
//
// Shares the single VGA frame-buffer write port between the screen producers
// (0 = greeting screen, 1 = playfield renderer, 2 = game-over screen). A
// producer raises its req bit for a whole burst and owns the port until it
// drops req or the grant has lasted MAX_HOLD cycles. Owners are chosen
// round-robin, starting after the previous winner. Between two grants there
// are always two dead cycles (GAP, then IDLE).
//
// Ports
//   clock      in   system clock, all state on rising edge
//   resetn     in   asynchronous active-low reset
//   req        in   per-requester burst request (level, held for the burst)
//   plot_in    in   per-requester pixel-valid strobe
//   x_in       in   packed x, slice i = x_in[i*X_W +: X_W]
//   y_in       in   packed y, same packing
//   color_in   in   packed colour, same packing
//   gnt        out  one-hot grant, all-zero when the port is free
//   VGA_X      out  registered x to the frame buffer
//   VGA_Y      out  registered y to the frame buffer
//   VGA_COLOR  out  registered colour to the frame buffer
//   VGA_PLOT   out  registered write enable to the frame buffer
//   busy       out  high while a grant is held (equals |gnt)
//   timeout    out  one-cycle pulse when a grant is revoked by MAX_HOLD
// ---------------------------------------------------------------------------
module m_vga_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 12,
  parameter int MAX_HOLD = 19200
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       plot_in,
  input  logic [NREQ*X_W-1:0]   x_in,
  input  logic [NREQ*Y_W-1:0]   y_in,
  input  logic [NREQ*C_W-1:0]   color_in,
  output logic [NREQ-1:0]       gnt,
  output logic [X_W-1:0]        VGA_X,
  output logic [Y_W-1:0]        VGA_Y,
  output logic [C_W-1:0]        VGA_COLOR,
  output logic                  VGA_PLOT,
  output logic                  busy,
  output logic                  timeout
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [NREQ-1:0]     gnt_q;
  logic [IDX_W-1:0]    last_q;     // previous winner; also the owner while in S_GRANT
  logic [HOLD_W-1:0]   hold_q;
  logic [X_W-1:0]      vga_x_q;
  logic [Y_W-1:0]      vga_y_q;
  logic [C_W-1:0]      vga_c_q;
  logic                plot_q;
  logic                busy_q;
  logic                timeout_q;

  // Round-robin pick: first set req bit searching upward from last_q+1.
  logic                rr_found_d;
  logic [IDX_W-1:0]    rr_winner_d;
  logic [IDX_W:0]      rr_idx;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rr_found_d  = 1'b0;
    rr_winner_d = '0;
    rr_idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_idx = {1'b0, last_q} + (IDX_W+1)'(k);
      if (rr_idx >= (IDX_W+1)'(NREQ)) rr_idx = rr_idx - (IDX_W+1)'(NREQ);
      if (!rr_found_d && req[rr_idx[IDX_W-1:0]]) begin
        rr_found_d  = 1'b1;
        rr_winner_d = rr_idx[IDX_W-1:0];
      end
    end
  end

  // Owner's slice. Constant-index selects keep the mux simple and width-clean.
  logic                own_req;
  logic                own_plot;
  logic [X_W-1:0]      own_x;
  logic [Y_W-1:0]      own_y;
  logic [C_W-1:0]      own_c;

  always_comb begin
    own_req  = 1'b0;
    own_plot = 1'b0;
    own_x    = '0;
    own_y    = '0;
    own_c    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_q == IDX_W'(i)) begin
        own_req  = req[i];
        own_plot = plot_in[i];
        own_x    = x_in[i*X_W +: X_W];
        own_y    = y_in[i*Y_W +: Y_W];
        own_c    = color_in[i*C_W +: C_W];
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);   // requester 0 wins first after reset
      hold_q    <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_c_q   <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      plot_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rr_found_d) begin
            gnt_q   <= NREQ'(1) << rr_winner_d;
            last_q  <= rr_winner_d;
            hold_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!own_req) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_GAP;
          end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
            // Revoked; the owner's req may stay high and re-competes in turn.
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= S_GAP;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
            plot_q <= own_plot;
            // Coordinates and colour only move with a real pixel, so the
            // frame-buffer bus holds its last value while VGA_PLOT is low.
            if (own_plot) begin
              vga_x_q <= own_x;
              vga_y_q <= own_y;
              vga_c_q <= own_c;
            end
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign VGA_X     = vga_x_q;
  assign VGA_Y     = vga_y_q;
  assign VGA_COLOR = vga_c_q;
  assign VGA_PLOT  = plot_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_m_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_m_vga_write_arbiter
//
// Directed bench for m_vga_write_arbiter (NREQ=3, MAX_HOLD=8). A table of
// per-cycle vectors covers a renderer burst, ignored non-owner strobes, owner
// release and a game-over burst; hand-written sequences cover the round-robin
// turnaround, MAX_HOLD revocation and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_m_vga_write_arbiter;

  localparam int NREQ = 3;
  localparam int X_W  = 8;
  localparam int Y_W  = 7;
  localparam int C_W  = 12;

  logic                clock  = 1'b0;
  logic                resetn = 1'b0;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     plot_in;
  logic [NREQ*X_W-1:0] x_in;
  logic [NREQ*Y_W-1:0] y_in;
  logic [NREQ*C_W-1:0] color_in;
  logic [NREQ-1:0]     gnt;
  logic [X_W-1:0]      VGA_X;
  logic [Y_W-1:0]      VGA_Y;
  logic [C_W-1:0]      VGA_COLOR;
  logic                VGA_PLOT;
  logic                busy;
  logic                timeout;

  int total = 0;
  int bad   = 0;

  m_vga_write_arbiter #(
    .NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .MAX_HOLD(8)
  ) dut (
    .clock(clock), .resetn(resetn), .req(req), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .color_in(color_in), .gnt(gnt),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .VGA_PLOT(VGA_PLOT),
    .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic [2:0] plot;
    logic [7:0] x0, x1, x2;
    logic [2:0] e_gnt;
    logic       e_plot;
    logic [7:0] e_x;
    logic       e_busy;
    logic       e_to;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // y and colour of each slice are derived from its x, so the expected
  // frame-buffer values follow from the expected x alone.
  function automatic logic [Y_W-1:0] y_of(input logic [7:0] x);
    return x[6:0] + 7'd1;
  endfunction

  function automatic logic [C_W-1:0] c_of(input logic [7:0] x);
    return {4'hA, x};
  endfunction

  task automatic set_x(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    x_in     = {c, b, a};
    y_in     = {y_of(c), y_of(b), y_of(a)};
    color_in = {c_of(c), c_of(b), c_of(a)};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    req     = '0;
    plot_in = '0;
    set_x(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Waits up to budget edges for a nonzero grant; idle counts zero-grant edges.
  task automatic wait_grant(input int budget, output logic [2:0] g, output int idle);
    g    = '0;
    idle = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (gnt != '0) begin
        g = gnt;
        return;
      end
      idle++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g;
    int         idle;
    int         cnt;
    logic [2:0] order[3];

    //            req     plot    x0     x1     x2     gnt     plot  x      busy  to
    vecs[0]  = '{3'b000, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 1'b0, 8'd0,  1'b0, 1'b0};
    vecs[1]  = '{3'b010, 3'b000, 8'd1,  8'd2,  8'd3,  3'b010, 1'b0, 8'd0,  1'b1, 1'b0};
    vecs[2]  = '{3'b010, 3'b010, 8'd0,  8'd5,  8'd0,  3'b010, 1'b1, 8'd5,  1'b1, 1'b0};
    vecs[3]  = '{3'b010, 3'b010, 8'd0,  8'd6,  8'd0,  3'b010, 1'b1, 8'd6,  1'b1, 1'b0};
    vecs[4]  = '{3'b010, 3'b010, 8'd0,  8'd7,  8'd0,  3'b010, 1'b1, 8'd7,  1'b1, 1'b0};
    vecs[5]  = '{3'b010, 3'b010, 8'd0,  8'd8,  8'd0,  3'b010, 1'b1, 8'd8,  1'b1, 1'b0};
    vecs[6]  = '{3'b010, 3'b101, 8'd99, 8'd9,  8'd99, 3'b010, 1'b0, 8'd8,  1'b1, 1'b0};
    vecs[7]  = '{3'b000, 3'b010, 8'd0,  8'd12, 8'd0,  3'b000, 1'b0, 8'd8,  1'b0, 1'b0};
    vecs[8]  = '{3'b000, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 1'b0, 8'd8,  1'b0, 1'b0};
    vecs[9]  = '{3'b100, 3'b000, 8'd0,  8'd0,  8'd0,  3'b100, 1'b0, 8'd8,  1'b1, 1'b0};
    vecs[10] = '{3'b100, 3'b100, 8'd0,  8'd0,  8'd33, 3'b100, 1'b1, 8'd33, 1'b1, 1'b0};
    vecs[11] = '{3'b100, 3'b110, 8'd0,  8'd77, 8'd34, 3'b100, 1'b1, 8'd34, 1'b1, 1'b0};
    vecs[12] = '{3'b000, 3'b100, 8'd0,  8'd0,  8'd35, 3'b000, 1'b0, 8'd34, 1'b0, 1'b0};

    // Reset values.
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_plot", 32'(VGA_PLOT), 32'h0);
    check("rst_x", 32'(VGA_X), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Table-driven burst sequence.
    for (int i = 0; i < 13; i++) begin
      req     = vecs[i].req;
      plot_in = vecs[i].plot;
      set_x(vecs[i].x0, vecs[i].x1, vecs[i].x2);
      step();
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d_plot", i), 32'(VGA_PLOT), 32'(vecs[i].e_plot));
      check($sformatf("v%0d_x", i), 32'(VGA_X), 32'(vecs[i].e_x));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'(vecs[i].e_to));
      if (vecs[i].e_plot) begin
        check($sformatf("v%0d_y", i), 32'(VGA_Y), 32'(y_of(vecs[i].e_x)));
        check($sformatf("v%0d_color", i), 32'(VGA_COLOR), 32'(c_of(vecs[i].e_x)));
      end
    end

    // Round-robin from reset with all three requesting; each holds 3 cycles.
    do_reset();
    req      = 3'b111;
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      wait_grant(10, g, idle);
      check($sformatf("rr%0d_gnt", i), 32'(g), 32'(order[i]));
      check($sformatf("rr%0d_gap", i), 32'(idle), (i == 0) ? 32'd0 : 32'd2);
      step();
      check($sformatf("rr%0d_hold2", i), 32'(gnt), 32'(order[i]));
      step();
      check($sformatf("rr%0d_hold3", i), 32'(gnt), 32'(order[i]));
      check($sformatf("rr%0d_busy", i), 32'(busy), 32'h1);
      req = req & ~order[i];
    end
    wait_grant(6, g, idle);
    check("rr_end_free", 32'(g), 32'h0);

    // MAX_HOLD revocation with requesters 0 and 1 both held.
    do_reset();
    req = 3'b011;
    wait_grant(5, g, idle);
    check("to_first_gnt", 32'(g), 32'h1);
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (gnt == 3'b001) cnt++;
      else break;
    end
    check("to_hold_len0", 32'(cnt), 32'd8);
    check("to_revoke_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    step();
    check("to_pulse_end", 32'(timeout), 32'h0);
    check("to_gap_gnt", 32'(gnt), 32'h0);
    wait_grant(5, g, idle);
    check("to_second_gnt", 32'(g), 32'h2);
    check("to_second_gap", 32'(idle), 32'd0);
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (gnt == 3'b010) cnt++;
      else break;
    end
    check("to_hold_len1", 32'(cnt), 32'd8);
    check("to_pulse1", 32'(timeout), 32'h1);
    step();
    wait_grant(5, g, idle);
    check("to_back_to_0", 32'(g), 32'h1);

    // Reset in the middle of a renderer burst.
    do_reset();
    req     = 3'b010;
    plot_in = 3'b010;
    set_x(8'd0, 8'd42, 8'd0);
    wait_grant(5, g, idle);
    check("mid_gnt", 32'(g), 32'h2);
    step();
    check("mid_plot", 32'(VGA_PLOT), 32'h1);
    check("mid_x", 32'(VGA_X), 32'd42);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_plot", 32'(VGA_PLOT), 32'h0);
    check("mid_rst_x", 32'(VGA_X), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    #1 resetn = 1'b1;
    wait_grant(5, g, idle);
    check("mid_regrant", 32'(g), 32'h2);
    check("mid_regrant_lat", 32'(idle), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
